// File: rtl/store_trace_checker.sv
// Observation-only monitor for the RV32I data-memory write port: traces stores,
// detects halt (pc self-loop) or timeout, then scores the trace against an expected table.
module store_trace_checker #(
    parameter int XLEN        = 32,
    parameter int DEPTH       = 16,
    parameter int HALT_CYCLES = 4,
    parameter int MAX_CYCLES  = 4096
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [XLEN-1:0]          pc,
    input  logic                     mem_write,
    input  logic [XLEN-1:0]          data_addr,
    input  logic [XLEN-1:0]          write_data,
    input  logic                     exp_wr_en,
    input  logic [$clog2(DEPTH)-1:0] exp_wr_idx,
    input  logic [XLEN-1:0]          exp_wr_addr,
    input  logic [XLEN-1:0]          exp_wr_data,
    input  logic [$clog2(DEPTH):0]   exp_count,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [XLEN-1:0]          rd_addr,
    output logic [XLEN-1:0]          rd_data,
    output logic [XLEN-1:0]          rd_pc,
    output logic [$clog2(DEPTH):0]   store_count,
    output logic                     overflow,
    output logic                     timeout,
    output logic [$clog2(DEPTH):0]   mismatch_cnt,
    output logic [$clog2(DEPTH):0]   first_fail,
    output logic                     busy,
    output logic                     done,
    output logic                     pass
);
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int HW  = $clog2(HALT_CYCLES);
    localparam int CYW = $clog2(MAX_CYCLES);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_CHECK, S_DONE} state_t;

    state_t state, next_state;

    logic [XLEN-1:0] trace_addr [DEPTH];
    logic [XLEN-1:0] trace_data [DEPTH];
    logic [XLEN-1:0] trace_pc   [DEPTH];
    logic [XLEN-1:0] exp_addr   [DEPTH];
    logic [XLEN-1:0] exp_data   [DEPTH];

    logic [CW-1:0]   exp_lat;
    logic [CW-1:0]   idx;
    logic [HW-1:0]   stable_cnt;
    logic [CYW-1:0]  cycle_cnt;
    logic [XLEN-1:0] prev_pc;

    logic            trace_full;
    logic            halt_hit;
    logic            time_hit;
    logic            start_run;
    logic [CW-1:0]   check_len;
    logic [AW-1:0]   idx_a;
    logic            entry_fail;

    assign trace_full = (store_count == DEPTH_C);
    assign start_run  = start && ((state == S_IDLE) || (state == S_DONE));
    // Halt fires on the edge where the self-loop count would reach HALT_CYCLES-1.
    assign halt_hit   = (state == S_RUN) && (pc == prev_pc) && (stable_cnt == HW'(HALT_CYCLES - 2));
    assign time_hit   = (state == S_RUN) && (cycle_cnt == CYW'(MAX_CYCLES - 1));
    assign check_len  = (store_count > exp_lat) ? store_count : exp_lat;
    assign idx_a      = idx[AW-1:0];
    assign entry_fail = (idx >= store_count) || (idx >= exp_lat) ||
                        (trace_addr[idx_a] != exp_addr[idx_a]) ||
                        (trace_data[idx_a] != exp_data[idx_a]);

    assign rd_addr = trace_addr[rd_idx];
    assign rd_data = trace_data[rd_idx];
    assign rd_pc   = trace_pc[rd_idx];

    assign busy = (state == S_RUN) || (state == S_CHECK);
    assign done = (state == S_DONE);
    assign pass = done && (mismatch_cnt == '0) && !overflow && !timeout;

    always_ff @(posedge clk) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = S_RUN;
            S_RUN:   if (halt_hit || time_hit) next_state = S_CHECK;
            S_CHECK: if (idx >= check_len) next_state = S_DONE;
            S_DONE:  if (start) next_state = S_RUN;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            store_count  <= '0;
            overflow     <= 1'b0;
            timeout      <= 1'b0;
            mismatch_cnt <= '0;
            first_fail   <= DEPTH_C;
            exp_lat      <= '0;
            idx          <= '0;
            stable_cnt   <= '0;
            cycle_cnt    <= '0;
            prev_pc      <= '0;
        end else if (start_run) begin
            store_count  <= '0;
            overflow     <= 1'b0;
            timeout      <= 1'b0;
            mismatch_cnt <= '0;
            first_fail   <= DEPTH_C;
            exp_lat      <= (exp_count > DEPTH_C) ? DEPTH_C : exp_count;
            idx          <= '0;
            stable_cnt   <= '0;
            cycle_cnt    <= '0;
            prev_pc      <= pc;
        end else if (state == S_RUN) begin
            if (mem_write) begin
                if (trace_full) overflow <= 1'b1;
                else            store_count <= store_count + 1'b1;
            end
            prev_pc    <= pc;
            stable_cnt <= (pc == prev_pc) ? stable_cnt + 1'b1 : '0;
            cycle_cnt  <= cycle_cnt + 1'b1;
            // A halt on the same edge as the timeout takes precedence.
            if (time_hit && !halt_hit) timeout <= 1'b1;
            idx <= '0;
        end else if (state == S_CHECK) begin
            if (idx < check_len) begin
                if (entry_fail) begin
                    mismatch_cnt <= mismatch_cnt + 1'b1;
                    if (first_fail == DEPTH_C) first_fail <= idx;
                end
                idx <= idx + 1'b1;
            end
        end
    end

    // Trace and expected storage carry no reset; contents survive reset_n.
    always_ff @(posedge clk) begin
        if (state == S_RUN && mem_write && !trace_full) begin
            trace_addr[store_count[AW-1:0]] <= data_addr;
            trace_data[store_count[AW-1:0]] <= write_data;
            trace_pc[store_count[AW-1:0]]   <= pc;
        end
        if (state == S_IDLE && exp_wr_en) begin
            exp_addr[exp_wr_idx] <= exp_wr_addr;
            exp_data[exp_wr_idx] <= exp_wr_data;
        end
    end

endmodule

// File: tb/tb_store_trace_checker.sv
// Directed bench for store_trace_checker (DEPTH=4, HALT_CYCLES=4, MAX_CYCLES=64).
module tb_store_trace_checker;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            start = 1'b0;
    logic [XLEN-1:0] pc = '0;
    logic            mem_write = 1'b0;
    logic [XLEN-1:0] data_addr = '0;
    logic [XLEN-1:0] write_data = '0;
    logic            exp_wr_en = 1'b0;
    logic [1:0]      exp_wr_idx = '0;
    logic [XLEN-1:0] exp_wr_addr = '0;
    logic [XLEN-1:0] exp_wr_data = '0;
    logic [2:0]      exp_count = '0;
    logic [1:0]      rd_idx = '0;
    logic [XLEN-1:0] rd_addr, rd_data, rd_pc;
    logic [2:0]      store_count, mismatch_cnt, first_fail;
    logic            overflow, timeout, busy, done, pass;

    int n_checks = 0;
    int n_pass   = 0;

    store_trace_checker #(.XLEN(XLEN), .DEPTH(4), .HALT_CYCLES(4), .MAX_CYCLES(64)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .pc(pc), .mem_write(mem_write),
        .data_addr(data_addr), .write_data(write_data), .exp_wr_en(exp_wr_en),
        .exp_wr_idx(exp_wr_idx), .exp_wr_addr(exp_wr_addr), .exp_wr_data(exp_wr_data),
        .exp_count(exp_count), .rd_idx(rd_idx), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_pc(rd_pc), .store_count(store_count), .overflow(overflow), .timeout(timeout),
        .mismatch_cnt(mismatch_cnt), .first_fail(first_fail), .busy(busy), .done(done),
        .pass(pass)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic load_exp(input logic [1:0] i, input logic [XLEN-1:0] a, input logic [XLEN-1:0] d);
        exp_wr_en = 1'b1; exp_wr_idx = i; exp_wr_addr = a; exp_wr_data = d;
        step();
        exp_wr_en = 1'b0;
    endtask

    task automatic start_run(input logic [2:0] cnt);
        pc = 32'h0; exp_count = cnt; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic core_store(input logic [XLEN-1:0] p, input logic [XLEN-1:0] a, input logic [XLEN-1:0] d);
        pc = p; mem_write = 1'b1; data_addr = a; write_data = d;
        step();
        mem_write = 1'b0;
    endtask

    // Park pc on a self-loop and wait for done; cycles counts edges until done shows.
    task automatic halt_and_wait(input logic [XLEN-1:0] p, output int cycles);
        pc = p;
        cycles = 0;
        for (int k = 0; k < 200; k++) begin
            step();
            cycles++;
            if (done) break;
        end
        n_checks++;
        if (done !== 1'b1) $display("FAIL done_wait: done=%0b after %0d cycles, required 1", done, cycles);
        else n_pass++;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (store_count !== 3'd0) $display("FAIL rst_store_count: got %0d need 0", store_count); else n_pass++;
        n_checks++; if (first_fail !== 3'd4) $display("FAIL rst_first_fail: got %0d need 4", first_fail); else n_pass++;
        n_checks++; if ({overflow, timeout, busy, done, pass} !== 5'b0) $display("FAIL rst_flags: got %b need 00000", {overflow, timeout, busy, done, pass}); else n_pass++;
        n_checks++; if (mismatch_cnt !== 3'd0) $display("FAIL rst_mismatch: got %0d need 0", mismatch_cnt); else n_pass++;
    endtask

    task automatic test_single_pass();
        int cyc;
        load_exp(2'd0, 32'd8, 32'd150);
        start_run(3'd1);
        n_checks++; if (busy !== 1'b1) $display("FAIL t1_busy: got %0b need 1", busy); else n_pass++;
        core_store(32'h4, 32'd8, 32'd150);
        halt_and_wait(32'h8, cyc);
        // 4 edges to detect the self-loop, then N+1=2 CHECK edges.
        n_checks++; if (cyc !== 6) $display("FAIL t1_latency: got %0d need 6", cyc); else n_pass++;
        n_checks++; if (pass !== 1'b1) $display("FAIL t1_pass: got %0b need 1", pass); else n_pass++;
        n_checks++; if (store_count !== 3'd1) $display("FAIL t1_store_count: got %0d need 1", store_count); else n_pass++;
        n_checks++; if (mismatch_cnt !== 3'd0) $display("FAIL t1_mismatch: got %0d need 0", mismatch_cnt); else n_pass++;
        n_checks++; if (first_fail !== 3'd4) $display("FAIL t1_first_fail: got %0d need 4", first_fail); else n_pass++;
    endtask

    task automatic test_data_mismatch();
        int cyc;
        start_run(3'd1);
        n_checks++; if ({done, pass} !== 2'b00) $display("FAIL t2_cleared: got %b need 00", {done, pass}); else n_pass++;
        core_store(32'h4, 32'd8, 32'd151);
        halt_and_wait(32'h8, cyc);
        n_checks++; if (pass !== 1'b0) $display("FAIL t2_pass: got %0b need 0", pass); else n_pass++;
        n_checks++; if (mismatch_cnt !== 3'd1) $display("FAIL t2_mismatch: got %0d need 1", mismatch_cnt); else n_pass++;
        n_checks++; if (first_fail !== 3'd0) $display("FAIL t2_first_fail: got %0d need 0", first_fail); else n_pass++;
        rd_idx = 2'd0;
        #1;
        n_checks++; if (rd_data !== 32'd151) $display("FAIL t2_rd_data: got %0d need 151", rd_data); else n_pass++;
        n_checks++; if (rd_addr !== 32'd8) $display("FAIL t2_rd_addr: got %0d need 8", rd_addr); else n_pass++;
        n_checks++; if (rd_pc !== 32'h4) $display("FAIL t2_rd_pc: got %0h need 4", rd_pc); else n_pass++;
    endtask

    task automatic test_overflow();
        int cyc;
        do_reset();
        for (int i = 0; i < 4; i++) load_exp(2'(i), 32'(16 + 4 * i), 32'(100 + i));
        start_run(3'd4);
        for (int i = 0; i < 6; i++) core_store(32'(4 + 4 * i), 32'(16 + 4 * i), 32'(100 + i));
        halt_and_wait(32'h40, cyc);
        n_checks++; if (overflow !== 1'b1) $display("FAIL t3_overflow: got %0b need 1", overflow); else n_pass++;
        n_checks++; if (store_count !== 3'd4) $display("FAIL t3_store_count: got %0d need 4", store_count); else n_pass++;
        n_checks++; if (mismatch_cnt !== 3'd0) $display("FAIL t3_mismatch: got %0d need 0", mismatch_cnt); else n_pass++;
        n_checks++; if (pass !== 1'b0) $display("FAIL t3_pass: got %0b need 0", pass); else n_pass++;
        rd_idx = 2'd3;
        #1;
        n_checks++; if (rd_data !== 32'd103) $display("FAIL t3_rd_last: got %0d need 103", rd_data); else n_pass++;
    endtask

    task automatic test_timeout();
        start_run(3'd0);
        for (int i = 1; i <= 63; i++) begin
            pc = pc + 32'd4;
            step();
        end
        n_checks++; if (timeout !== 1'b0) $display("FAIL t4_early_timeout: got %0b need 0", timeout); else n_pass++;
        pc = pc + 32'd4;
        step();
        n_checks++; if (timeout !== 1'b1) $display("FAIL t4_timeout: got %0b need 1", timeout); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL t4_busy: got %0b need 1", busy); else n_pass++;
        pc = pc + 32'd4;
        step();
        n_checks++; if (done !== 1'b1) $display("FAIL t4_done: got %0b need 1", done); else n_pass++;
        n_checks++; if (pass !== 1'b0) $display("FAIL t4_pass: got %0b need 0", pass); else n_pass++;
    endtask

    task automatic test_short_trace();
        int cyc;
        do_reset();
        for (int i = 0; i < 3; i++) load_exp(2'(i), 32'(32 + 4 * i), 32'(200 + i));
        start_run(3'd3);
        core_store(32'h4, 32'd32, 32'd200);
        core_store(32'h8, 32'd36, 32'd201);
        halt_and_wait(32'hC, cyc);
        n_checks++; if (mismatch_cnt !== 3'd1) $display("FAIL t5_mismatch: got %0d need 1", mismatch_cnt); else n_pass++;
        n_checks++; if (first_fail !== 3'd2) $display("FAIL t5_first_fail: got %0d need 2", first_fail); else n_pass++;
        n_checks++; if (pass !== 1'b0) $display("FAIL t5_pass: got %0b need 0", pass); else n_pass++;
        start_run(3'd0);
        halt_and_wait(32'h0, cyc);
        // pc already equals prev_pc: 3 edges to halt, 1 CHECK edge.
        n_checks++; if (cyc !== 4) $display("FAIL t5_empty_latency: got %0d need 4", cyc); else n_pass++;
        n_checks++; if (pass !== 1'b1) $display("FAIL t5_empty_pass: got %0b need 1", pass); else n_pass++;
        n_checks++; if (store_count !== 3'd0) $display("FAIL t5_empty_count: got %0d need 0", store_count); else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        start_run(3'd1);
        core_store(32'h4, 32'd32, 32'd200);
        core_store(32'h8, 32'd36, 32'd201);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        n_checks++; if (busy !== 1'b0) $display("FAIL t6_busy: got %0b need 0", busy); else n_pass++;
        n_checks++; if (store_count !== 3'd0) $display("FAIL t6_store_count: got %0d need 0", store_count); else n_pass++;
        start_run(3'd1);
        // Expected-table writes outside IDLE must be ignored.
        load_exp(2'd0, 32'd99, 32'd99);
        core_store(32'h4, 32'd32, 32'd200);
        halt_and_wait(32'h8, cyc);
        n_checks++; if (pass !== 1'b1) $display("FAIL t6_pass: got %0b need 1", pass); else n_pass++;
        n_checks++; if (store_count !== 3'd1) $display("FAIL t6_store_count2: got %0d need 1", store_count); else n_pass++;
        n_checks++; if (mismatch_cnt !== 3'd0) $display("FAIL t6_mismatch: got %0d need 0", mismatch_cnt); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_data_mismatch();
        test_overflow();
        test_timeout();
        test_short_trace();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
